// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift/compare ops, plus iterative
// shift-add multiply and restoring divide/remainder, one bit per cycle.
module alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [OPRN_WIDTH-1:0] OPRN,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  output logic [DATA_WIDTH-1:0] OUT,
  output logic [DATA_WIDTH-1:0] HI,
  output logic                  ZERO,
  output logic                  DONE,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(W);
  localparam int CW  = $clog2(W) + 1;

  localparam logic [OPRN_WIDTH-1:0] OP_ADD  = OPRN_WIDTH'(6'h20);
  localparam logic [OPRN_WIDTH-1:0] OP_SUB  = OPRN_WIDTH'(6'h22);
  localparam logic [OPRN_WIDTH-1:0] OP_MUL  = OPRN_WIDTH'(6'h2c);
  localparam logic [OPRN_WIDTH-1:0] OP_SRL  = OPRN_WIDTH'(6'h02);
  localparam logic [OPRN_WIDTH-1:0] OP_SLL  = OPRN_WIDTH'(6'h01);
  localparam logic [OPRN_WIDTH-1:0] OP_SRA  = OPRN_WIDTH'(6'h03);
  localparam logic [OPRN_WIDTH-1:0] OP_AND  = OPRN_WIDTH'(6'h24);
  localparam logic [OPRN_WIDTH-1:0] OP_OR   = OPRN_WIDTH'(6'h25);
  localparam logic [OPRN_WIDTH-1:0] OP_NOR  = OPRN_WIDTH'(6'h27);
  localparam logic [OPRN_WIDTH-1:0] OP_SLT  = OPRN_WIDTH'(6'h2a);
  localparam logic [OPRN_WIDTH-1:0] OP_SLTS = OPRN_WIDTH'(6'h2b);
  localparam logic [OPRN_WIDTH-1:0] OP_DIVU = OPRN_WIDTH'(6'h1a);
  localparam logic [OPRN_WIDTH-1:0] OP_REMU = OPRN_WIDTH'(6'h1b);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;   // MUL: product high half; DIV: partial remainder
  logic [W-1:0]    lo_q, lo_d;     // MUL: multiplier/product low; DIV: dividend/quotient
  logic [W-1:0]    b_q, b_d;       // MUL: multiplicand; DIV: divisor
  logic            is_rem_q, is_rem_d;
  logic [W-1:0]    out_q, out_d;
  logic [W-1:0]    hi_q, hi_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Single-cycle operation decode
  logic [W-1:0]        alu_res;
  logic                alu_err;
  logic                sh_big;
  logic [SHW-1:0]      sh_amt;
  logic signed [W-1:0] sra_s;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    sh_big  = (OP2 >= W'(W));
    sh_amt  = OP2[SHW-1:0];
    // NOTE: kept in its own signed variable so the arithmetic shift is not
    // silently turned logical by an unsigned operand in a surrounding ternary.
    sra_s   = $signed(OP1) >>> sh_amt;
    case (OPRN)
      OP_ADD:  alu_res = OP1 + OP2;
      OP_SUB:  alu_res = OP1 - OP2;
      OP_SLL:  alu_res = sh_big ? '0 : (OP1 << sh_amt);
      OP_SRL:  alu_res = sh_big ? '0 : (OP1 >> sh_amt);
      OP_SRA:  alu_res = sh_big ? {W{OP1[W-1]}} : sra_s;
      OP_AND:  alu_res = OP1 & OP2;
      OP_OR:   alu_res = OP1 | OP2;
      OP_NOR:  alu_res = ~(OP1 | OP2);
      OP_SLT:  alu_res = {{(W-1){1'b0}}, (OP1 < OP2)};
      OP_SLTS: alu_res = {{(W-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
      default: alu_err = 1'b1;
    endcase
  end

  // One shift-add multiply step and one restoring divide step
  logic [W:0]   mul_sum;
  logic [W-1:0] mul_acc, mul_lo;
  logic [W:0]   div_shift, div_diff;
  logic [W-1:0] div_acc, div_lo;
  logic         last_iter;

  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
  assign mul_acc   = mul_sum[W:1];
  assign mul_lo    = {mul_sum[0], lo_q[W-1:1]};
  assign div_shift = {acc_q, lo_q[W-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_acc   = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
  assign div_lo    = {lo_q[W-2:0], ~div_diff[W]};
  assign last_iter = (cnt_q == CW'(W - 1));

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    b_d      = b_q;
    is_rem_d = is_rem_q;
    out_d    = out_q;
    hi_d     = hi_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          cnt_d = '0;
          case (OPRN)
            OP_MUL: begin
              acc_d   = '0;
              lo_d    = OP2;
              b_d     = OP1;
              state_d = S_MUL;
            end
            OP_DIVU, OP_REMU: begin
              if (OP2 == '0) begin
                out_d  = (OPRN == OP_REMU) ? OP1 : '1;
                hi_d   = '0;
                err_d  = 1'b1;
                done_d = 1'b1;
              end else begin
                acc_d    = '0;
                lo_d     = OP1;
                b_d      = OP2;
                is_rem_d = (OPRN == OP_REMU);
                state_d  = S_DIV;
              end
            end
            default: begin
              out_d  = alu_res;
              hi_d   = '0;
              err_d  = alu_err;
              done_d = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        lo_d  = mul_lo;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          out_d   = mul_lo;
          hi_d    = mul_acc;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        acc_d = div_acc;
        lo_d  = div_lo;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          out_d   = is_rem_q ? div_acc : div_lo;
          hi_d    = '0;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    zero_d = done_d ? (out_d == '0) : zero_q;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // NOTE: working operands need no reset; they are always loaded on START
  // before any iteration reads them.
  always_ff @(posedge CLK) begin
    acc_q    <= acc_d;
    lo_q     <= lo_d;
    b_q      <= b_d;
    is_rem_q <= is_rem_d;
  end

  assign OUT  = out_q;
  assign HI   = hi_q;
  assign ZERO = zero_q;
  assign DONE = done_q;
  assign ERR  = err_q;
  assign BUSY = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 32-bit and 8-bit instances, vector tables for
// single-cycle ops and hand-written sequences for multiply/divide and reset.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s32_start, s32_zero, s32_done, s32_busy, s32_err;
  logic [5:0]  s32_oprn;
  logic [31:0] s32_op1, s32_op2, s32_out, s32_hi;
  logic        s8_start, s8_zero, s8_done, s8_busy, s8_err;
  logic [5:0]  s8_oprn;
  logic [7:0]  s8_op1, s8_op2, s8_out, s8_hi;

  alu_seq #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) u_dut32 (
    .CLK(clk), .RST(rst), .START(s32_start), .OPRN(s32_oprn),
    .OP1(s32_op1), .OP2(s32_op2), .OUT(s32_out), .HI(s32_hi),
    .ZERO(s32_zero), .DONE(s32_done), .BUSY(s32_busy), .ERR(s32_err)
  );

  alu_seq #(.DATA_WIDTH(8), .OPRN_WIDTH(6)) u_dut8 (
    .CLK(clk), .RST(rst), .START(s8_start), .OPRN(s8_oprn),
    .OP1(s8_op1), .OP2(s8_op2), .OUT(s8_out), .HI(s8_hi),
    .ZERO(s8_zero), .DONE(s8_done), .BUSY(s8_busy), .ERR(s8_err)
  );

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t v32 [18];
  vec_t v8  [8];

  int checks   = 0;
  int failures = 0;

  logic [31:0] o_out, o_hi;
  logic        o_zero, o_done, o_busy, o_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic st, input logic [5:0] opc,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      s8_start = st; s8_oprn = opc; s8_op1 = a[7:0]; s8_op2 = b[7:0];
    end else begin
      s32_start = st; s32_oprn = opc; s32_op1 = a; s32_op2 = b;
    end
  endtask

  task automatic sample(input bit w8);
    if (w8) begin
      o_out = {24'h0, s8_out}; o_hi = {24'h0, s8_hi};
      o_zero = s8_zero; o_done = s8_done; o_busy = s8_busy; o_err = s8_err;
    end else begin
      o_out = s32_out; o_hi = s32_hi;
      o_zero = s32_zero; o_done = s32_done; o_busy = s32_busy; o_err = s32_err;
    end
  endtask

  task automatic check_reset_state(input bit w8, input string tag);
    sample(w8);
    check({tag, "_out"},  o_out,  0);
    check({tag, "_hi"},   o_hi,   0);
    check({tag, "_zero"}, o_zero, 1);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_err"},  o_err,  0);
  endtask

  // Drives START for one cycle; leaves START high so calls chain back-to-back.
  task automatic apply_vec(input bit w8, input vec_t v, input int idx);
    string tag;
    tag = $sformatf("%s_v%0d", w8 ? "w8" : "w32", idx);
    @(negedge clk);
    drive(w8, 1'b1, v.opc, v.a, v.b);
    @(posedge clk); #1;
    sample(w8);
    check({tag, "_done"}, o_done, 1);
    check({tag, "_out"},  o_out,  v.out);
    check({tag, "_hi"},   o_hi,   0);
    check({tag, "_zero"}, o_zero, v.zero);
    check({tag, "_err"},  o_err,  v.err);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic run_iter(input bit w8, input string tag, input logic [5:0] opc,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic [31:0] exp_hi,
                          input bit inject);
    int width;
    int lat;
    bit busy_ok;
    width = w8 ? 8 : 32;
    @(negedge clk);
    drive(w8, 1'b1, opc, a, b);
    @(posedge clk); #1;
    sample(w8);
    check({tag, "_busy_start"}, o_busy, 1);
    check({tag, "_done_start"}, o_done, 0);
    lat = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= width + 4; n++) begin
      @(negedge clk);
      drive(w8, inject && (n == 3), 6'h20, 32'h5A5A_5A5A, 32'h3);
      @(posedge clk); #1;
      sample(w8);
      if (o_done) begin
        lat = n;
        break;
      end
      if (!o_busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, lat, width);
    check({tag, "_busy_held"}, busy_ok, 1);
    check({tag, "_out"},  o_out,  exp_out);
    check({tag, "_hi"},   o_hi,   exp_hi);
    check({tag, "_zero"}, o_zero, (exp_out == 0));
    check({tag, "_err"},  o_err,  0);
    check({tag, "_busy_end"}, o_busy, 0);
    @(negedge clk);
    drive(w8, 1'b0, 6'h20, 32'h0, 32'h0);
    @(posedge clk); #1;
    sample(w8);
    check({tag, "_done_strobe"}, o_done, 0);
    check({tag, "_out_hold"}, o_out, exp_out);
  endtask

  initial begin
    bit saw_done;

    v32[0]  = '{6'h20, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0}; // ADD wrap
    v32[1]  = '{6'h22, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1'b0}; // SUB
    v32[2]  = '{6'h03, 32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0, 1'b0}; // SRA
    v32[3]  = '{6'h03, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 1'b0, 1'b0}; // SRA big
    v32[4]  = '{6'h02, 32'h8000_0000, 32'h4,         32'h0800_0000, 1'b0, 1'b0}; // SRL
    v32[5]  = '{6'h02, 32'h8000_0000, 32'd32,        32'h0,         1'b1, 1'b0}; // SRL big
    v32[6]  = '{6'h01, 32'h1,         32'd32,        32'h0,         1'b1, 1'b0}; // SLL big
    v32[7]  = '{6'h01, 32'h1,         32'd31,        32'h8000_0000, 1'b0, 1'b0}; // SLL
    v32[8]  = '{6'h2b, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0}; // SLTS
    v32[9]  = '{6'h2a, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0}; // SLT
    v32[10] = '{6'h24, 32'hF0F0,      32'h0FF0,      32'h00F0,      1'b0, 1'b0}; // AND
    v32[11] = '{6'h25, 32'hF0F0,      32'h0FF0,      32'hFFF0,      1'b0, 1'b0}; // OR
    v32[12] = '{6'h27, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0}; // NOR
    v32[13] = '{6'h03, 32'h7FFF_FFFF, 32'd100,       32'h0,         1'b1, 1'b0}; // SRA big pos
    v32[14] = '{6'h1a, 32'h5,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1}; // DIVU /0
    v32[15] = '{6'h1b, 32'h9,         32'h0,         32'h9,         1'b0, 1'b1}; // REMU /0
    v32[16] = '{6'h3f, 32'h1234,      32'h5678,      32'h0,         1'b1, 1'b1}; // bad opcode
    v32[17] = '{6'h22, 32'h0,         32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0}; // SUB wrap

    v8[0] = '{6'h20, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0};
    v8[1] = '{6'h22, 32'h05, 32'h07, 32'hFE, 1'b0, 1'b0};
    v8[2] = '{6'h1a, 32'h05, 32'h00, 32'hFF, 1'b0, 1'b1};
    v8[3] = '{6'h1b, 32'h09, 32'h00, 32'h09, 1'b0, 1'b1};
    v8[4] = '{6'h03, 32'h80, 32'h09, 32'hFF, 1'b0, 1'b0};
    v8[5] = '{6'h02, 32'h80, 32'h08, 32'h00, 1'b1, 1'b0};
    v8[6] = '{6'h2b, 32'hFF, 32'h01, 32'h01, 1'b0, 1'b0};
    v8[7] = '{6'h3f, 32'h12, 32'h34, 32'h00, 1'b1, 1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 6'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 6'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(1'b0, "rst32");
    check_reset_state(1'b1, "rst8");
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle ops, back-to-back
    for (int i = 0; i < 18; i++) apply_vec(1'b0, v32[i], i);
    @(negedge clk);
    drive(1'b0, 1'b0, 6'h0, 32'h0, 32'h0);

    // Iterative ops; the first has a START pulsed mid-operation
    run_iter(1'b0, "mul_ff", 6'h2c, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    run_iter(1'b0, "mul_sh", 6'h2c, 32'h1234_5678, 32'h10,        32'h2345_6780, 32'h1,         1'b0);
    run_iter(1'b0, "divu",   6'h1a, 32'd100,       32'd7,         32'd14,        32'h0,         1'b0);
    run_iter(1'b0, "remu",   6'h1b, 32'd100,       32'd7,         32'd2,         32'h0,         1'b0);
    run_iter(1'b0, "divu_b", 6'h1a, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'h0,         1'b1);
    run_iter(1'b0, "remu_b", 6'h1b, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0,         1'b0);

    // Reset in the middle of a multiply
    begin
      vec_t pre;
      vec_t post;
      pre  = '{6'h20, 32'h3,    32'h4,    32'h7,    1'b0, 1'b0};
      post = '{6'h24, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0};
      apply_vec(1'b0, pre, 100);
      @(negedge clk);
      drive(1'b0, 1'b1, 6'h2c, 32'hFFFF_FFFF, 32'h3);
      @(negedge clk);
      drive(1'b0, 1'b0, 6'h0, 32'h0, 32'h0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_state(1'b0, "mid_rst");
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk); #1;
        if (s32_done || s32_busy) saw_done = 1'b1;
      end
      check("mid_rst_no_done", saw_done, 0);
      apply_vec(1'b0, post, 101);
      @(negedge clk);
      drive(1'b0, 1'b0, 6'h0, 32'h0, 32'h0);
    end

    // 8-bit instance
    for (int i = 0; i < 8; i++) apply_vec(1'b1, v8[i], i);
    @(negedge clk);
    drive(1'b1, 1'b0, 6'h0, 32'h0, 32'h0);
    run_iter(1'b1, "w8_mul",  6'h2c, 32'hFF,  32'hFF, 32'h01, 32'hFE, 1'b1);
    run_iter(1'b1, "w8_divu", 6'h1a, 32'd100, 32'd7,  32'h0E, 32'h00, 1'b0);
    run_iter(1'b1, "w8_remu", 6'h1b, 32'd100, 32'd7,  32'h02, 32'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the combinational 32-bit ALU. It accepts one operation per START pulse and returns the result with a DONE strobe. Logic, add/sub, shift and compare ops complete in 1 cycle. Multiply (shift-add) and divide/remainder (restoring) are iterative. It sits in the datapath between the register-file read ports and the writeback mux; the control unit stalls on BUSY.

Parameters:
DATA_WIDTH, 32, operand/result width in bits (>=4).
OPRN_WIDTH, 6, opcode width in bits.

Ports:
CLK  input  1  clock, all state updates on rising edge.
RST  input  1  synchronous, active-high reset.
START  input  1  request; sampled only when BUSY=0.
OPRN  input  OPRN_WIDTH  operation code, latched with START.
OP1  input  DATA_WIDTH  operand 1, latched with START.
OP2  input  DATA_WIDTH  operand 2, latched with START.
OUT  output  DATA_WIDTH  result (low word for MUL).
HI  output  DATA_WIDTH  upper word of MUL product; 0 for all other ops.
ZERO  output  1  1 when OUT==0; registered with OUT.
DONE  output  1  one-cycle strobe: OUT/HI/ZERO/ERR valid and updated this cycle.
BUSY  output  1  1 while an iterative op is in progress.
ERR  output  1  1 with DONE for an invalid opcode or divide by zero.

Behaviour:
- Reset (RST=1 at edge): OUT=0, HI=0, ZERO=1, DONE=0, BUSY=0, ERR=0, state=IDLE, counter=0. Reset overrides everything, including an operation in flight, which is discarded with no DONE.
- Opcodes (hex): 20 ADD, 22 SUB, 2c MUL (unsigned), 02 SRL, 01 SLL, 03 SRA (new), 24 AND, 25 OR, 27 NOR, 2a SLT (unsigned, OUT=1/0), 2b SLTS signed (new), 1a DIVU quotient (new), 1b REMU remainder (new). Any other code gives OUT=0, HI=0, ERR=1.
- ADD/SUB wrap modulo 2^DATA_WIDTH. No overflow flag.
- Shifts use the full OP2 value as the shift amount. Amount >= DATA_WIDTH gives 0 for SRL/SLL and all bits = OP1 MSB for SRA.
- States: IDLE, MUL, DIV.
  - IDLE: START=1 with a single-cycle op. Result is registered at that edge, DONE=1 in the following cycle, and the state stays IDLE (latency 1).
  - IDLE: START=1 with MUL or DIVU/REMU. Operands are latched, BUSY=1 from the next cycle, counter=0, state goes to MUL or DIV.
  - MUL/DIV: one bit per cycle, DATA_WIDTH iterations. On the last iteration the result registers load, DONE=1 and BUSY=0 in the next cycle, and the state returns to IDLE.
  - Total latency for START sampled at edge k: DONE high in the cycle after edge k+DATA_WIDTH.
- Divide by zero (OP2=0): resolved in IDLE with no iteration. DIVU gives OUT = all ones, REMU gives OUT = OP1, ERR=1, latency 1.
- START while BUSY=1 is ignored; no queueing, and latched operands are unaffected.
- START in the same cycle as DONE=1 (state IDLE) is accepted, giving back-to-back throughput of 1 op/cycle for single-cycle ops.
- OUT, HI, ZERO and ERR hold their values between DONE strobes. They change only on a DONE-producing edge or on reset.
- Counter width is ceil(log2(DATA_WIDTH))+1. No wrap is reachable.

Test Plan:
1. Reset, then START ADD with OP1=FFFFFFFF, OP2=1 -> next cycle DONE=1, OUT=0, ZERO=1, ERR=0. Follow with back-to-back START SUB 5-7 -> OUT=FFFFFFFE, ZERO=0.
2. START MUL with OP1=FFFFFFFF, OP2=FFFFFFFF -> BUSY=1 for 32 cycles, DONE in cycle 33 after START, HI=FFFFFFFE, OUT=00000001. A START pulsed mid-operation is ignored.
3. DIVU 100/7 -> OUT=14 (0x0E). REMU 100/7 -> OUT=2. DIVU 5/0 -> latency 1, OUT=FFFFFFFF, ERR=1.
4. SRA 80000000 by 4 -> F8000000. SRA by 40 -> FFFFFFFF. SLL 1 by 32 -> 0, ZERO=1. SLTS FFFFFFFF vs 1 -> 1. SLT FFFFFFFF vs 1 -> 0.
5. RST asserted at cycle 10 of a MUL -> no DONE, BUSY=0, OUT=0 next cycle. A following AND F0F0 & 0FF0 -> 00F0.
6. Opcode 3f -> DONE, ERR=1, OUT=0. Repeat tests 1-3 with DATA_WIDTH=8: MUL FF*FF gives HI=FE, OUT=01 at latency 9.
